gfx_sp_lane_serializer: RTL and testbench
=========================================

// Module: gfx_sp_lane_serializer
// PURPOSE
//   Consumes the shader processor's send stream: one packet per handshake, carrying
//   LANES lane words plus an active-lane mask. Emits only the active lanes, one per
//   cycle, lowest lane index first, tagged with lane index and last-of-packet.
//   Sits directly downstream of gfx_sp's send_* port and feeds the per-vertex consumer.
// PARAMETERS
//   LANES    4    lanes per send packet; power of two, >= 2
//   WORD_W   128  bits per lane word (vec4 of 32-bit components)
//   CNT_W    16   width of the emitted-lane statistics counter
// PORTS
//   clk         in   1              clock
//   rst_n       in   1              asynchronous active-low reset
//   send_valid  in   1              upstream packet valid
//   send_ready  out  1              packet accepted when send_valid && send_ready
//   send_data   in   LANES*WORD_W   lane i occupies bits [i*WORD_W +: WORD_W]
//   send_mask   in   LANES          bit i set = lane i active
//   out_valid   out  1              emitted lane valid
//   out_ready   in   1              downstream accepts when out_valid && out_ready
//   out_data    out  WORD_W         active lane word
//   out_lane    out  $clog2(LANES)  index of the emitted lane
//   out_last    out  1              no active lanes remain in this packet after this one
//   emit_count  out  CNT_W          total lanes emitted since reset; wraps modulo 2**CNT_W
// BEHAVIOUR
//   - Reset (rst_n low, async): busy=0, pending mask=0, out_valid=0, out_lane=0,
//     out_last=0, out_data=0, emit_count=0. send_ready=1 from the first edge after release.
//   - Storage: one packet register (data + pending mask). No further buffering.
//   - States: IDLE (pending==0) and EMIT (pending!=0); busy = (pending!=0).
//   - send_ready = !busy || (out_valid && out_ready && out_last); combinational, so
//     back-to-back packets issue with no bubble.
//   - Accept (send_valid && send_ready): capture send_data; pending <= send_mask.
//     First active lane appears on out_* in the next cycle (latency 1).
//   - Zero mask: packet is accepted and discarded; no output; state stays IDLE.
//   - EMIT: out_lane = index of lowest set bit of pending; out_data = that lane's word;
//     out_last = (pending has exactly one bit set); out_valid = busy.
//   - On out handshake: clear that bit of pending; emit_count += 1.
//     If it was the last bit and no accept happens in the same cycle, go to IDLE.
//   - Simultaneous last-lane handshake and accept: the new packet replaces the old
//     one in the same edge; out_valid stays high if the new mask is nonzero.
//   - Backpressure: while out_valid && !out_ready, out_data, out_lane and out_last
//     stay stable. send_ready stays 0 while busy and the last lane is not yet accepted.
//   - out_* are driven from registered state only (pending mask and captured data);
//     there is no combinational path from send_* to out_*.
//   - Reset asserted mid-packet: the pending packet is dropped; no partial output
//     after release.
// TESTING
//   1. Reset, then mask=4'b1111 with lane words 0xA0..0xA3 and out_ready=1 -> out_lane
//      0,1,2,3 on 4 consecutive cycles; out_last only on lane 3; emit_count=4.
//   2. Mask=4'b1010 -> exactly two outputs (lane 1, then lane 3 with out_last=1);
//      send_ready=0 until lane 3 handshakes.
//   3. Mask=4'b0000 followed by mask=4'b0001 -> no output for the first packet;
//      lane 0 emitted with out_last=1 in the cycle after the second accept.
//   4. Two packets, each mask=4'b0011, send_valid held high, out_ready=1 -> four
//      consecutive out_valid cycles with no bubble; second accept coincides with
//      the lane-1 handshake.
//   5. out_ready toggled 1,0,0,1 during mask=4'b0111 -> outputs stable while stalled;
//      lane order 0,1,2; no duplicated or dropped lane.
//   6. Assert rst_n for one cycle after lane 0 of a mask=4'b1111 packet -> out_valid=0
//      and emit_count=0 immediately; send_ready=1 after release; old lanes never appear.

Source files
------------

// File: rtl/gfx_sp_lane_serializer.sv
`timescale 1ns/1ps
// gfx_sp_lane_serializer
// Takes one multi-lane send packet per handshake from the shader processor and
// replays only its active lanes, lowest index first, one lane per cycle, with
// the lane index and a last-of-packet flag. A single packet register is the
// only storage; the next packet is accepted on the same edge that retires the
// final lane of the current one, so back-to-back packets stream without a bubble.
module gfx_sp_lane_serializer #(
  parameter int LANES  = 4,
  parameter int WORD_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       send_valid,
  output logic                       send_ready,
  input  logic [LANES*WORD_W-1:0]    send_data,
  input  logic [LANES-1:0]           send_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic [$clog2(LANES)-1:0]   out_lane,
  output logic                       out_last,
  output logic [CNT_W-1:0]           emit_count
);

  localparam int LW = $clog2(LANES);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                    st_p1;
  state_t                    st_d;
  logic [LANES-1:0]          pend_p1;
  logic [LANES-1:0]          pend_d;
  logic [LANES-1:0]          low_bit;
  logic [LANES*WORD_W-1:0]   data_p1;
  logic                      ready_en;
  logic                      busy;
  logic                      out_hs;
  logic                      accept;

  // Isolate the lowest set bit of a lane mask (two's-complement trick).
  function automatic logic [LANES-1:0] lowest_bit(input logic [LANES-1:0] m);
    return m & (~m + LANES'(1));
  endfunction

  // Index of the lowest set bit; zero when the mask is empty.
  function automatic logic [LW-1:0] lowest_idx(input logic [LANES-1:0] m);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  // True when exactly one lane remains pending.
  function automatic logic single_bit(input logic [LANES-1:0] m);
    return (m != '0) && ((m & (m - LANES'(1))) == '0);
  endfunction

  // Control state: FSM state, pending lane mask, ready enable and the lane counter.
  // ready_en keeps send_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_p1      <= IDLE;
      pend_p1    <= '0;
      ready_en   <= 1'b0;
      emit_count <= '0;
    end else begin
      st_p1    <= st_d;
      pend_p1  <= pend_d;
      ready_en <= 1'b1;
      if (out_hs) emit_count <= emit_count + CNT_W'(1);
    end
  end

  // Packet word capture; data only, qualified by the pending mask so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) data_p1 <= send_data;
  end

  // Next pending mask and state: retire the emitted lane, then let an accept overwrite.
  always_comb begin
    pend_d = pend_p1;
    if (out_hs) pend_d = pend_p1 & ~low_bit;
    if (accept) pend_d = send_mask;
    st_d = (pend_d != '0) ? EMIT : IDLE;
  end

  // Outputs decoded from registered state only; send_ready may look at out_ready
  // so the final lane and the next packet can share one edge.
  always_comb begin
    busy       = (st_p1 == EMIT);
    low_bit    = lowest_bit(pend_p1);
    out_valid  = busy;
    out_lane   = busy ? lowest_idx(pend_p1) : '0;
    out_last   = busy && single_bit(pend_p1);
    out_data   = busy ? data_p1[int'(out_lane)*WORD_W +: WORD_W] : '0;
    out_hs     = out_valid && out_ready;
    send_ready = ready_en && (!busy || (out_hs && out_last));
    accept     = send_valid && send_ready;
  end

endmodule

// File: tb/tb_gfx_sp_lane_serializer.sv
`timescale 1ns/1ps
// Directed bench for gfx_sp_lane_serializer: a queue-based packet model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_gfx_sp_lane_serializer;

  localparam int LANES  = 4;
  localparam int WORD_W = 128;
  localparam int CNT_W  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     send_valid;
  logic                     send_ready;
  logic [LANES*WORD_W-1:0]  send_data;
  logic [LANES-1:0]         send_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_W-1:0]        out_data;
  logic [1:0]               out_lane;
  logic                     out_last;
  logic [CNT_W-1:0]         emit_count;

  gfx_sp_lane_serializer #(.LANES(LANES), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_valid (send_valid),
    .send_ready (send_ready),
    .send_data  (send_data),
    .send_mask  (send_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .emit_count (emit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        lane;
    logic [WORD_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t             mq[$];
  logic [CNT_W-1:0] m_cnt = '0;
  bit               m_ren = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] log_lanes;
  logic [31:0] log_last;
  int          log_n;
  int          cyc_no = 0;
  int          v_n, first_v, last_v;

  task automatic chk(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_ren && ((mq.size() == 0) || ((mq.size() == 1) && out_ready));
  endfunction

  // Behavioural model: a packet becomes a list of its active lanes; each output
  // handshake pops one entry, each accept appends the new packet's lanes.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_cnt = '0;
        m_ren = 1'b0;
      end else begin
        bit hs, acc;
        int last_i;
        hs  = (mq.size() != 0) && out_ready;
        acc = send_valid && m_ready();
        if (hs) begin
          void'(mq.pop_front());
          m_cnt = m_cnt + 1'b1;
        end
        if (acc) begin
          last_i = -1;
          for (int i = 0; i < LANES; i++) if (send_mask[i]) last_i = i;
          for (int i = 0; i < LANES; i++) begin
            if (send_mask[i]) begin
              exp_t e;
              e.lane = 2'(i);
              e.data = send_data[i*WORD_W +: WORD_W];
              e.last = (i == last_i);
              mq.push_back(e);
            end
          end
        end
        m_ren = 1'b1;
      end
    end
  end

  // Per-cycle compare at mid-cycle, plus a log of the lanes actually handed off.
  initial begin
    forever begin
      @(negedge clk);
      cyc_no++;
      if (chk_en) begin
        chk("out_valid", WORD_W'(out_valid), WORD_W'(mq.size() != 0));
        chk("send_ready", WORD_W'(send_ready), WORD_W'(m_ready()));
        chk("emit_count", WORD_W'(emit_count), WORD_W'(m_cnt));
        if (mq.size() != 0) begin
          chk("out_data", out_data, mq[0].data);
          chk("out_lane", WORD_W'(out_lane), WORD_W'(mq[0].lane));
          chk("out_last", WORD_W'(out_last), WORD_W'(mq[0].last));
        end
        if (out_valid === 1'b1) begin
          if (v_n == 0) first_v = cyc_no;
          last_v = cyc_no;
          v_n++;
          if (out_ready) begin
            log_lanes = (log_lanes << 4) | 32'(out_lane);
            log_last  = (log_last << 1) | 32'(out_last);
            log_n++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_log();
    log_lanes = '0;
    log_last  = '0;
    log_n     = 0;
    v_n       = 0;
    first_v   = 0;
    last_v    = 0;
  endtask

  function automatic logic [LANES*WORD_W-1:0] pack4(input logic [WORD_W-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  initial begin
    rst_n      = 1'b1;
    send_valid = 1'b0;
    send_mask  = '0;
    send_data  = '0;
    out_ready  = 1'b0;
    clr_log();
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    cyc(2);
    chk("rst_out_valid", WORD_W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_lane", WORD_W'(out_lane), '0);
    chk("rst_out_last", WORD_W'(out_last), '0);
    chk("rst_emit_count", WORD_W'(emit_count), '0);
    rst_n = 1'b1;
    cyc(2);
    chk("ready_after_release", WORD_W'(send_ready), WORD_W'(1));

    // Scenario 1: full mask, all four lanes in order.
    clr_log();
    out_ready  = 1'b1;
    send_valid = 1'b1;
    send_mask  = 4'b1111;
    send_data  = pack4(128'hA0, 128'hA1, 128'hA2, 128'hA3);
    cyc(1);
    send_valid = 1'b0;
    cyc(6);
    chk("t1_lanes", WORD_W'(log_lanes), WORD_W'(32'h0123));
    chk("t1_count", WORD_W'(log_n), WORD_W'(4));
    chk("t1_last", WORD_W'(log_last), WORD_W'(4'b0001));
    chk("t1_emit_count", WORD_W'(emit_count), WORD_W'(4));

    // Scenario 2: sparse mask 1010.
    clr_log();
    send_valid = 1'b1;
    send_mask  = 4'b1010;
    send_data  = pack4(128'hD0, 128'hD1, 128'hD2, 128'hD3);
    cyc(1);
    send_valid = 1'b0;
    chk("t2_ready_busy", WORD_W'(send_ready), '0);
    chk("t2_first_lane", WORD_W'(out_lane), WORD_W'(1));
    cyc(4);
    chk("t2_lanes", WORD_W'(log_lanes), WORD_W'(32'h13));
    chk("t2_count", WORD_W'(log_n), WORD_W'(2));
    chk("t2_last", WORD_W'(log_last), WORD_W'(2'b01));

    // Scenario 3: empty packet discarded, then single-lane packet.
    clr_log();
    send_valid = 1'b1;
    send_mask  = 4'b0000;
    send_data  = pack4(128'hBAD0, 128'hBAD1, 128'hBAD2, 128'hBAD3);
    cyc(1);
    chk("t3_idle_after_zero", WORD_W'(out_valid), '0);
    send_mask  = 4'b0001;
    send_data  = pack4(128'hC0, 128'hC1, 128'hC2, 128'hC3);
    cyc(1);
    send_valid = 1'b0;
    chk("t3_valid", WORD_W'(out_valid), WORD_W'(1));
    chk("t3_lane", WORD_W'(out_lane), '0);
    chk("t3_last", WORD_W'(out_last), WORD_W'(1));
    chk("t3_data", out_data, 128'hC0);
    cyc(3);
    chk("t3_count", WORD_W'(log_n), WORD_W'(1));

    // Scenario 4: back-to-back packets, accept overlaps the last-lane handshake.
    clr_log();
    send_valid = 1'b1;
    send_mask  = 4'b0011;
    send_data  = pack4(128'hE0, 128'hE1, 128'hE2, 128'hE3);
    cyc(1);
    send_data  = pack4(128'hF0, 128'hF1, 128'hF2, 128'hF3);
    cyc(1);
    chk("t4_ready_at_last", WORD_W'(send_ready), WORD_W'(1));
    cyc(1);
    send_valid = 1'b0;
    chk("t4_second_data", out_data, 128'hF0);
    cyc(4);
    chk("t4_lanes", WORD_W'(log_lanes), WORD_W'(32'h0101));
    chk("t4_last", WORD_W'(log_last), WORD_W'(4'b0101));
    chk("t4_valid_cycles", WORD_W'(v_n), WORD_W'(4));
    chk("t4_no_bubble", WORD_W'(last_v - first_v + 1), WORD_W'(4));

    // Scenario 5: backpressure pattern 1,0,0,1 on mask 0111.
    clr_log();
    send_valid = 1'b1;
    send_mask  = 4'b0111;
    send_data  = pack4(128'h60, 128'h61, 128'h62, 128'h63);
    cyc(1);
    send_valid = 1'b0;
    out_ready  = 1'b1;
    cyc(1);
    out_ready  = 1'b0;
    chk("t5_stall1_lane", WORD_W'(out_lane), WORD_W'(1));
    chk("t5_stall1_data", out_data, 128'h61);
    cyc(1);
    chk("t5_stall2_lane", WORD_W'(out_lane), WORD_W'(1));
    chk("t5_stall2_data", out_data, 128'h61);
    chk("t5_stall_ready", WORD_W'(send_ready), '0);
    cyc(1);
    out_ready  = 1'b1;
    cyc(4);
    chk("t5_lanes", WORD_W'(log_lanes), WORD_W'(32'h012));
    chk("t5_count", WORD_W'(log_n), WORD_W'(3));
    chk("t5_last", WORD_W'(log_last), WORD_W'(3'b001));

    // Scenario 6: reset mid-packet after lane 0.
    clr_log();
    send_valid = 1'b1;
    send_mask  = 4'b1111;
    send_data  = pack4(128'h70, 128'h71, 128'h72, 128'h73);
    cyc(1);
    send_valid = 1'b0;
    cyc(1);
    chk("t6_pre_lanes", WORD_W'(log_lanes), '0);
    chk("t6_pre_count", WORD_W'(log_n), WORD_W'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", WORD_W'(out_valid), '0);
    chk("t6_rst_emit_count", WORD_W'(emit_count), '0);
    cyc(1);
    rst_n = 1'b1;
    clr_log();
    cyc(1);
    chk("t6_ready_after", WORD_W'(send_ready), WORD_W'(1));
    cyc(5);
    chk("t6_no_old_lanes", WORD_W'(v_n), '0);
    chk("t6_emit_count", WORD_W'(emit_count), '0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
